// File: rtl/ref_window_fetch_pkg.sv
// ref_window_fetch_pkg
// Shared constants and state encoding for the reference-window fetcher.
// A window is 15x15 8-bit pixels, read as two 128-bit words per row and
// streamed as 120-bit rows.
package ref_window_fetch_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN       = 15;
    localparam int WORD_PIX  = 16;
    localparam int ROW_BITS  = 120;
    localparam int WORD_BITS = 128;
    localparam int N_READS   = 2 * WIN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/ref_window_fetch_if.sv
// ref_window_fetch_if
// Memory read port and row-stream output of the reference-window fetcher.
//   mem_rd_en/mem_addr : read strobe and word address (fetcher -> memory)
//   mem_rd_data        : 128-bit word, valid the cycle after mem_rd_en
//   row_out/row_valid  : 120-bit row stream (fetcher -> interpolator)
//   row_last/done      : flags accompanying the final row
// master = fetcher side, slave = memory / row consumer side.
interface ref_window_fetch_if
    import ref_window_fetch_pkg::*;
#(
    parameter int ADDR_W = 20
) ();

    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_BITS-1:0] mem_rd_data;
    logic [ROW_BITS-1:0]  row_out;
    logic                 row_valid;
    logic                 row_last;
    logic                 done;

    modport master (
        output mem_rd_en, mem_addr, row_out, row_valid, row_last, done,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en, mem_addr, row_out, row_valid, row_last, done,
        output mem_rd_data
    );

endinterface

// File: rtl/ref_window_fetch_row_aligner.sv
// ref_window_fetch_row_aligner
// Combinational byte shifter: picks 15 consecutive pixels out of two
// adjacent memory words starting at pixel offset `offset` of word0.
//   word0, word1 : lower and upper 128-bit words of one window row
//   offset       : pixel offset of the window's left edge inside word0
//   row          : 15 pixels, pixel k at [8k+7:8k]
module ref_window_fetch_row_aligner
    import ref_window_fetch_pkg::*;
(
    input  logic [WORD_BITS-1:0] word0,
    input  logic [WORD_BITS-1:0] word1,
    input  logic [3:0]           offset,
    output logic [ROW_BITS-1:0]  row
);

    logic [2*WORD_BITS-1:0] cat_s;
    logic [4:0]             src_s;

    // Byte-wise select; offset+k never exceeds 29, so the top bytes of word1 are never needed.
    always_comb begin
        cat_s = {word1, word0};
        row   = '0;
        src_s = 5'd0;
        for (int k = 0; k < WIN; k++) begin
            src_s = {1'b0, offset} + 5'(k);
            row[k*PIX_W +: PIX_W] = cat_s[src_s*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/ref_window_fetch.sv
// ref_window_fetch
// Fetches a 15x15 reference window (two word reads per row, 30 reads),
// buffers the aligned rows, then streams them on 15 consecutive cycles.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   start              : request, sampled only while idle
//   base_addr          : word address of frame row 0, word 0
//   blk_x, blk_y       : window top-left (blk_y signed), registered at start
//   busy               : high from first read through last streamed row
//   err                : one-cycle pulse when the window leaves the frame vertically
//   bus (master)       : memory read port and row stream
// Build option: define REF_CLAMP_EN to clamp row indices into the frame
// (vertical edge replication); err then never fires.
module ref_window_fetch
    import ref_window_fetch_pkg::*;
#(
    parameter int FRAME_W = 1920,
    parameter int FRAME_H = 1080,
    parameter int ADDR_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [11:0]         blk_x,
    input  logic signed [12:0]  blk_y,
    output logic                busy,
    output logic                err,
    ref_window_fetch_if.master  bus
);

    localparam logic signed [13:0] Y_MAX = 14'(FRAME_H - 1);

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [11:0]          blk_x_q, blk_x_d;
    logic signed [12:0]   blk_y_q, blk_y_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [ROW_BITS-1:0]  row_out_q, row_out_d;
    logic                 row_valid_q, row_valid_d;
    logic                 row_last_q, row_last_d;
    logic                 done_q, done_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [4:0]           rd_idx_q, rd_idx_d;
    logic [WORD_BITS-1:0] word0_q, word0_d;
    logic [ROW_BITS-1:0]  buffer_q [0:WIN-1];
    logic                 buf_we_s;
    logic [3:0]           buf_row_s;
    logic [3:0]           nxt_row_s;
    logic [ROW_BITS-1:0]  aligned_s;

    // Word address of read idx (row idx>>1, half idx&1) for a given window origin.
    function automatic logic [ADDR_W-1:0] read_addr(
        input logic [ADDR_W-1:0]  base,
        input logic [11:0]        bx,
        input logic signed [12:0] by,
        input logic [4:0]         idx
    );
        logic signed [13:0] y;
        logic [ADDR_W-1:0]  row;
        y = $signed({by[12], by}) + $signed({10'd0, idx[4:1]});
`ifdef REF_CLAMP_EN
        if (y < 14'sd0) begin
            y = 14'sd0;
        end else if (y > Y_MAX) begin
            y = Y_MAX;
        end else begin
            y = y;
        end
`endif
        // Negative rows wrap modulo the address space when not clamped.
        row = {{(ADDR_W-14){y[13]}}, y};
        return base + row * ADDR_W'(FRAME_W / WORD_PIX) + ADDR_W'(bx[11:4]) + ADDR_W'(idx[0]);
    endfunction

`ifndef REF_CLAMP_EN
    // True when any of the 15 window rows falls outside the frame.
    function automatic logic range_err(input logic signed [12:0] by);
        logic signed [13:0] y_last;
        y_last = $signed({by[12], by}) + 14'sd14;
        return by[12] | (y_last > Y_MAX);
    endfunction
`endif

    ref_window_fetch_row_aligner u_aligner (
        .word0  (word0_q),
        .word1  (bus.mem_rd_data),
        .offset (blk_x_q[3:0]),
        .row    (aligned_s)
    );

    // Read-data capture: even reads hold the low word, odd reads complete a row.
    always_comb begin
        rd_vld_d  = mem_rd_en_q;
        rd_idx_d  = cnt_q;
        buf_we_s  = rd_vld_q & rd_idx_q[0];
        buf_row_s = rd_idx_q[4:1];
        if (rd_vld_q && !rd_idx_q[0]) begin
            word0_d = bus.mem_rd_data;
        end else begin
            word0_d = word0_q;
        end
    end

    // FSM next state and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_x_d     = blk_x_q;
        blk_y_d     = blk_y_q;
        base_d      = base_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        row_out_d   = row_out_q;
        row_valid_d = 1'b0;
        row_last_d  = 1'b0;
        done_d      = 1'b0;
        nxt_row_s   = cnt_q[3:0] + 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    cnt_d       = 5'd0;
                    blk_x_d     = blk_x;
                    blk_y_d     = blk_y;
                    base_d      = base_addr;
                    busy_d      = 1'b1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = read_addr(base_addr, blk_x, blk_y, 5'd0);
`ifdef REF_CLAMP_EN
                    err_d       = 1'b0;
`else
                    err_d       = range_err(blk_y);
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (cnt_q == 5'(N_READS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d       = cnt_q + 5'd1;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = read_addr(base_q, blk_x_q, blk_y_q, cnt_q + 5'd1);
                end
            end
            ST_DRAIN: begin
                // Row 14 lands in the buffer at the end of this cycle; row 0 is long ready.
                state_d     = ST_STREAM;
                cnt_d       = 5'd0;
                row_valid_d = 1'b1;
                row_out_d   = buffer_q[0];
            end
            ST_STREAM: begin
                if (cnt_q == 5'(WIN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d       = cnt_q + 5'd1;
                    row_valid_d = 1'b1;
                    row_out_d   = buffer_q[nxt_row_s];
                    row_last_d  = (nxt_row_s == 4'(WIN - 1));
                    done_d      = (nxt_row_s == 4'(WIN - 1));
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            blk_x_q     <= 12'd0;
            blk_y_q     <= 13'sd0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            row_out_q   <= '0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= 5'd0;
            word0_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_x_q     <= blk_x_d;
            blk_y_q     <= blk_y_d;
            base_q      <= base_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            row_out_q   <= row_out_d;
            row_valid_q <= row_valid_d;
            row_last_q  <= row_last_d;
            done_q      <= done_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            word0_q     <= word0_d;
        end
    end

    // Row buffer; contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buffer_q[buf_row_s] <= aligned_s;
        end
    end

    assign busy          = busy_q;
    assign err           = err_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.row_out   = row_out_q;
    assign bus.row_valid = row_valid_q;
    assign bus.row_last  = row_last_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ref_window_fetch.sv
// tb_ref_window_fetch
// Table of window requests run back to back against a frame-memory model
// with pixel(x,y) = (x+3y)&0xFF, base 0, 120 words per row. Expected read
// addresses and rows are queued at start and popped as the DUT produces them.
module tb_ref_window_fetch;

    logic              clk;
    logic              rst;
    logic              start;
    logic [19:0]       base_addr;
    logic [11:0]       blk_x;
    logic signed [12:0] blk_y;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] bx;
        int          by;
        bit          err_nc;  // err expected when clamping is not built in
        logic [7:0]  p0;      // hand-derived row 0 pixel 0
    } vec_t;

    typedef struct {
        logic [119:0] row;
        bit           care;
    } row_exp_t;

    logic [19:0] exp_addr_q[$];
    row_exp_t    exp_row_q[$];
    vec_t        vecs[7];

    ref_window_fetch_if #(.ADDR_W(20)) bus ();

    ref_window_fetch #(.FRAME_W(1920), .FRAME_H(1080), .ADDR_W(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .blk_x     (blk_x),
        .blk_y     (blk_y),
        .busy      (busy),
        .err       (err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mem_word(input logic [19:0] a);
        int y, wx;
        logic [127:0] w;
        y  = int'(a) / 120;
        wx = int'(a) % 120;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'((16 * wx + k + 3 * y) & 255);
        return w;
    endfunction

    // Memory model: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_addr);
    end

    function automatic int exp_y(input int by, input int r);
        int y;
        y = by + r;
`ifdef REF_CLAMP_EN
        if (y < 0) y = 0;
        if (y > 1079) y = 1079;
`endif
        return y;
    endfunction

    function automatic logic [119:0] pix_row(input int bx, input int y);
        logic [119:0] r;
        for (int k = 0; k < 15; k++) r[8*k +: 8] = 8'((bx + k + 3 * y) & 255);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete request starting at the current negedge (cycle 0).
    task automatic run_one(input vec_t v);
        bit          e;
        int          rows_seen;
        int          y;
        logic [5:0]  exp_ctrl;
        logic [19:0] ea;
        row_exp_t    er;
`ifdef REF_CLAMP_EN
        e = 1'b0;
`else
        e = v.err_nc;
`endif
        for (int i = 0; i < 30; i++) begin
            y = exp_y(v.by, i >> 1);
            exp_addr_q.push_back(20'((y * 120 + int'(v.bx >> 4) + (i & 1)) & 32'hFFFFF));
        end
        for (int r = 0; r < 15; r++) begin
            y = exp_y(v.by, r);
            er.row  = pix_row(int'(v.bx), y);
            er.care = (y >= 0);
            exp_row_q.push_back(er);
        end
        rows_seen = 0;
        base_addr = 20'd0;
        blk_x     = v.bx;
        blk_y     = 13'(v.by);
        start     = 1'b1;
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                blk_x = ~v.bx;
                blk_y = ~13'(v.by);
            end
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            exp_ctrl = {(c <= 46), (c <= 30), (c >= 32 && c <= 46), (c == 46), (c == 46), (c == 1 && e)};
            chk($sformatf("ctrl busy/rd/vld/last/done/err c=%0d", c),
                {busy, bus.mem_rd_en, bus.row_valid, bus.row_last, bus.done, err}, exp_ctrl);
            if (bus.mem_rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_addr: unexpected read at %0h", bus.mem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("mem_addr", bus.mem_addr, ea);
                end
            end
            if (bus.row_valid) begin
                if (exp_row_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL row_out: unexpected row %0h", bus.row_out);
                end else begin
                    er = exp_row_q.pop_front();
                    if (er.care) begin
                        chk($sformatf("row_out r=%0d bx=%0d", rows_seen, v.bx), bus.row_out, er.row);
                        if (rows_seen == 0) chk("row0_pix0", bus.row_out[7:0], v.p0);
                    end
                end
                rows_seen++;
            end
        end
        chk("reads_missing", exp_addr_q.size(), 0);
        chk("rows_missing", exp_row_q.size(), 0);
        exp_addr_q.delete();
        exp_row_q.delete();
    endtask

    initial begin
        vecs[0] = '{bx: 12'd32,   by: 4,    err_nc: 1'b0, p0: 8'd44};
        vecs[1] = '{bx: 12'd37,   by: 0,    err_nc: 1'b0, p0: 8'd37};
        vecs[2] = '{bx: 12'd0,    by: -3,   err_nc: 1'b1, p0: 8'd0};
        vecs[3] = '{bx: 12'd1905, by: 0,    err_nc: 1'b0, p0: 8'd113};
        vecs[4] = '{bx: 12'd200,  by: 1070, err_nc: 1'b1, p0: 8'd82};
        vecs[5] = '{bx: 12'd15,   by: 100,  err_nc: 1'b0, p0: 8'd59};
        vecs[6] = '{bx: 12'd1,    by: 1065, err_nc: 1'b0, p0: 8'd124};

        rst       = 1'b0;
        start     = 1'b0;
        base_addr = 20'd0;
        blk_x     = 12'd0;
        blk_y     = 13'sd0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, err, bus.mem_rd_en, bus.row_valid, bus.row_last, bus.done, bus.mem_addr, bus.row_out}, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle outputs", {busy, err, bus.mem_rd_en, bus.row_valid, bus.row_last, bus.done}, 128'd0);

        for (int v = 0; v < 7; v++) run_one(vecs[v]);

        // Reset in the middle of a fetch aborts it at once.
        blk_x = vecs[0].bx;
        blk_y = 13'(vecs[0].by);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        chk("busy before reset", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort busy/rd/vld", {busy, bus.mem_rd_en, bus.row_valid}, 3'b000);
        repeat (2) begin
            @(negedge clk);
            chk("held busy/rd/vld", {busy, bus.mem_rd_en, bus.row_valid}, 3'b000);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset idle", {busy, bus.mem_rd_en, bus.row_valid, bus.done}, 4'b0000);
        run_one(vecs[0]);
        run_one(vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
